arith_result_collector: RTL and testbench

Receive end of the arithmetic result demux path. It captures 16-bit results arriving on four sel-indexed channels (y1..y4) into per-channel holding registers. It arbitrates round-robin between pending channels and re-serialises them onto one registered output stream with a channel tag and a valid/ready handshake. It sits downstream of the arithmetic unit plus 1-to-4 demux and feeds a single consumer (display/log/writeback).

---
 rtl/arith_result_collector.sv | 92 +++++++++
 tb/tb_arith_result_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/arith_result_collector.sv
// Collects sel-indexed arithmetic results into per-channel holding regs and re-serialises them round-robin.
// Latency: capture at edge N -> out_valid/y/sel registered after edge N+1; sustains one result per cycle.
// Backpressure: out_valid&!out_ready freezes the output register and ptr; new captures overwrite pending data (ovf).
module arith_result_collector #(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             el,
    input  logic [3:0]       in_valid,
    input  logic [W-1:0]     y1,
    input  logic [W-1:0]     y2,
    input  logic [W-1:0]     y3,
    input  logic [W-1:0]     y4,
    output logic [W-1:0]     y,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ovf,
    output logic [CNT_W-1:0] out_count
);

    logic [W-1:0] hold [4];
    logic [W-1:0] yin  [4];
    logic [3:0]   pend;
    logic [3:0]   cap;
    logic [3:0]   gnt_vec;
    logic [1:0]   ptr;
    logic [1:0]   gnt_idx;
    logic [1:0]   scan_idx;
    logic         gnt_vld;
    logic         free;
    logic         xfer;

    assign yin[0] = y1;
    assign yin[1] = y2;
    assign yin[2] = y3;
    assign yin[3] = y4;

    assign cap  = el ? 4'b0000 : in_valid;
    assign free = !out_valid || out_ready;
    assign xfer = free && gnt_vld;

    // Scan from the farthest offset down so the nearest pending channel to ptr wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = ptr;
        scan_idx = ptr;
        for (int j = 3; j >= 0; j--) begin
            scan_idx = ptr + 2'(j);
            if (pend[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign gnt_vec = xfer ? (4'b0001 << gnt_idx) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            pend      <= '0;
            ptr       <= '0;
            y         <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            ovf       <= '0;
            out_count <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cap[i]) hold[i] <= yin[i];
            end
            // A capture on the channel being transferred refills it rather than overwriting it.
            pend <= cap | (pend & ~gnt_vec);
            ovf  <= ovf | (cap & pend & ~gnt_vec);

            if (out_valid && out_ready) out_count <= out_count + CNT_W'(1);

            if (xfer) begin
                y         <= hold[gnt_idx];
                sel       <= gnt_idx;
                out_valid <= 1'b1;
                ptr       <= gnt_idx + 2'd1;
            end else if (free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arith_result_collector.sv
// Directed self-checking bench for arith_result_collector.
module tb_arith_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        el;
    logic [3:0]  in_valid;
    logic [15:0] y1, y2, y3, y4;
    logic [15:0] y;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ovf;
    logic [7:0]  out_count;

    int checks   = 0;
    int failures = 0;

    arith_result_collector #(.W(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .el       (el),
        .in_valid (in_valid),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y4       (y4),
        .y        (y),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf      (ovf),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; el = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
        y1 = '0; y2 = '0; y3 = '0; y4 = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++; if (y !== 16'h0)        begin failures++; $display("FAIL reset_y got=%h exp=0000", y); end
        checks++; if (sel !== 2'd0)       begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (ovf !== 4'b0000)    begin failures++; $display("FAIL reset_ovf got=%b exp=0000", ovf); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    endtask

    task automatic test_single();
        out_ready = 1'b1; el = 1'b0;
        y2 = 16'h00C8; in_valid = 4'b0010;
        tick();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_lat0 valid got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (y !== 16'h00C8)     begin failures++; $display("FAIL single_y got=%h exp=00c8", y); end
        checks++; if (sel !== 2'd1)       begin failures++; $display("FAIL single_sel got=%0d exp=1", sel); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", out_valid); end
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", out_count); end
    endtask

    task automatic test_round_robin();
        do_reset();
        y1 = 16'd1; y2 = 16'd2; y3 = 16'd3; y4 = 16'd4;
        in_valid = 4'b1111;
        tick();
        in_valid = 4'b0000;
        tick();
        tick();
        // Held under backpressure
        checks++; if (out_valid !== 1'b1 || y !== 16'd1 || sel !== 2'd0)
            begin failures++; $display("FAIL rr_hold got v=%b y=%0d sel=%0d exp v=1 y=1 sel=0", out_valid, y, sel); end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || sel !== 2'(i) || y !== 16'(i + 1))
                begin failures++; $display("FAIL rr_seq%0d got v=%b y=%0d sel=%0d exp y=%0d sel=%0d", i, out_valid, y, sel, i + 1, i); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_empty got=%b exp=0", out_valid); end
        checks++; if (out_count !== 8'd4) begin failures++; $display("FAIL rr_count got=%0d exp=4", out_count); end
        y1 = 16'h0011; y3 = 16'h0033; in_valid = 4'b0101;
        tick();
        in_valid = 4'b0000;
        tick();
        checks++; if (sel !== 2'd0 || y !== 16'h0011 || out_valid !== 1'b1)
            begin failures++; $display("FAIL rr_wrap0 got v=%b y=%h sel=%0d exp y=0011 sel=0", out_valid, y, sel); end
        tick();
        checks++; if (sel !== 2'd2 || y !== 16'h0033 || out_valid !== 1'b1)
            begin failures++; $display("FAIL rr_wrap2 got v=%b y=%h sel=%0d exp y=0033 sel=2", out_valid, y, sel); end
        tick();
        checks++; if (out_count !== 8'd6) begin failures++; $display("FAIL rr_count2 got=%0d exp=6", out_count); end
    endtask

    task automatic test_backpressure_overwrite();
        do_reset();
        y1 = 16'h00A0; y4 = 16'h0010; in_valid = 4'b1001;
        tick();
        in_valid = 4'b0000;
        tick();
        y4 = 16'h0020; in_valid = 4'b1000;
        tick();
        in_valid = 4'b0000;
        checks++; if (ovf !== 4'b1000) begin failures++; $display("FAIL bp_ovf got=%b exp=1000", ovf); end
        checks++; if (y !== 16'h00A0 || sel !== 2'd0 || out_valid !== 1'b1)
            begin failures++; $display("FAIL bp_held got v=%b y=%h sel=%0d exp y=00a0 sel=0", out_valid, y, sel); end
        out_ready = 1'b1;
        tick();
        checks++; if (y !== 16'h0020 || sel !== 2'd3 || out_valid !== 1'b1)
            begin failures++; $display("FAIL bp_newest got v=%b y=%h sel=%0d exp y=0020 sel=3", out_valid, y, sel); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_lost got=%b exp=0", out_valid); end
        // Capture and transfer on the same channel in one cycle
        y2 = 16'h0055; in_valid = 4'b0010;
        tick();
        y2 = 16'h0066;
        tick();
        in_valid = 4'b0000;
        checks++; if (y !== 16'h0055 || sel !== 2'd1) begin failures++; $display("FAIL same_old got y=%h sel=%0d exp y=0055 sel=1", y, sel); end
        checks++; if (ovf !== 4'b1000) begin failures++; $display("FAIL same_ovf got=%b exp=1000", ovf); end
        tick();
        checks++; if (y !== 16'h0066 || sel !== 2'd1 || out_valid !== 1'b1)
            begin failures++; $display("FAIL same_new got v=%b y=%h sel=%0d exp y=0066 sel=1", out_valid, y, sel); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_count !== 8'd4)
            begin failures++; $display("FAIL same_end got v=%b cnt=%0d exp v=0 cnt=4", out_valid, out_count); end
    endtask

    task automatic test_enable();
        do_reset();
        out_ready = 1'b1;
        el = 1'b1; in_valid = 4'b1111;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL en_gate got=%b exp=0", out_valid); end
        el = 1'b0; y3 = 16'h0077; in_valid = 4'b0100;
        tick();
        el = 1'b1; y1 = 16'hBEEF; y3 = 16'hDEAD; in_valid = 4'b1111;
        tick();
        checks++; if (out_valid !== 1'b1 || y !== 16'h0077 || sel !== 2'd2)
            begin failures++; $display("FAIL en_drain got v=%b y=%h sel=%0d exp y=0077 sel=2", out_valid, y, sel); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL en_nocap got=%b exp=0", out_valid); end
        el = 1'b0; in_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        y1 = 16'h0101; y2 = 16'h0202; y3 = 16'h0303; in_valid = 4'b0111;
        tick();
        in_valid = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || y !== 16'h0 || sel !== 2'd0 || ovf !== 4'b0 || out_count !== 8'd0)
            begin failures++; $display("FAIL mid_rst got v=%b y=%h sel=%0d ovf=%b cnt=%0d exp all zero", out_valid, y, sel, ovf, out_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 259; i++) begin
            y1 = 16'(i); in_valid = 4'b0001;
            tick();
            if (i >= 1) begin
                checks++; if (out_valid !== 1'b1 || y !== 16'(i - 1))
                    begin failures++; $display("FAIL b2b_%0d got v=%b y=%0d exp y=%0d", i, out_valid, y, i - 1); end
            end
            if (i == 257) begin
                checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL b2b_wrap got=%0d exp=0", out_count); end
            end
        end
        in_valid = 4'b0000;
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", out_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure_overwrite();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
